// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and drives the imem read handshake.
// A word can be parked across ID stalls, and redirects from later stages
// can be applied. Fetching stops after the HALT word.
module fetch_stage #(
    parameter logic [31:0] PC_INIT    = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        ifW,
    output logic        ifRST,
    output logic [31:0] ifinstr,
    output logic [31:0] ifJALjump_addr,
    output logic [31:0] fetch_count,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] holdQ;
    logic [31:0] fetchCount;
    logic        haltedQ;
    logic [31:0] pcPlus4;

    assign pcPlus4        = pc + 32'd4;
    assign imemaddr       = pc;
    assign ifJALjump_addr = pcPlus4;
    assign fetch_count    = fetchCount;
    assign halted         = haltedQ;

    // PC, parked word, counter and halt flag; a redirect overrides every state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            holdQ      <= '0;
            fetchCount <= '0;
            haltedQ    <= 1'b0;
        end else if (redirect) begin
            state   <= FETCH;
            pc      <= redirect_addr & 32'hFFFF_FFFC;
            holdQ   <= '0;
            haltedQ <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        if (!stall) begin
                            pc         <= pcPlus4;
                            fetchCount <= fetchCount + 32'd1;
                            if (imemload == HALT_INSTR) begin
                                state   <= HALTED;
                                haltedQ <= 1'b1;
                            end
                        end else begin
                            holdQ <= imemload;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc         <= pcPlus4;
                        fetchCount <= fetchCount + 32'd1;
                        if (holdQ == HALT_INSTR) begin
                            state   <= HALTED;
                            haltedQ <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // IF/ID handshake and imem enable, decoded from state and this cycle's inputs
    always_comb begin
        imemREN = 1'b0;
        ifW     = 1'b0;
        ifRST   = redirect;
        ifinstr = imemload;
        case (state)
            FETCH: begin
                imemREN = 1'b1;
                ifW     = ihit && !stall && !redirect;
            end
            HOLD: begin
                ifinstr = holdQ;
                ifW     = !stall && !redirect;
            end
            default: begin
                ifW = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus a hand-written async reset sequence.
module tb_fetch_stage;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ifW;
    logic        ifRST;
    logic [31:0] ifinstr;
    logic [31:0] ifJALjump_addr;
    logic [31:0] fetch_count;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        stall;
        logic        redir;
        logic [31:0] raddr;
        logic        eRen;
        logic [31:0] eAddr;
        logic        eW;
        logic        eRst;
        logic [31:0] eInstr;
        logic [31:0] eJal;
        logic [31:0] eFc;
        logic        eHalt;
    } vec_t;

    vec_t vq[$];

    fetch_stage #(
        .PC_INIT   (32'h0000_0000),
        .HALT_INSTR(32'hFFFF_FFFF)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .imemload      (imemload),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .ifW           (ifW),
        .ifRST         (ifRST),
        .ifinstr       (ifinstr),
        .ifJALjump_addr(ifJALjump_addr),
        .fetch_count   (fetch_count),
        .halted        (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec%0d got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic addV(input logic ih, input logic [31:0] ld, input logic st, input logic rd,
                        input logic [31:0] ra, input logic ren, input logic [31:0] addr,
                        input logic w, input logic rst, input logic [31:0] ins,
                        input logic [31:0] jal, input logic [31:0] fc, input logic h);
        vec_t v;
        v = '{ih, ld, st, rd, ra, ren, addr, w, rst, ins, jal, fc, h};
        vq.push_back(v);
    endtask

    task automatic checkAll(input int idx, input vec_t v);
        chk("imemREN",  idx, {31'd0, imemREN}, {31'd0, v.eRen});
        chk("imemaddr", idx, imemaddr, v.eAddr);
        chk("ifW",      idx, {31'd0, ifW}, {31'd0, v.eW});
        chk("ifRST",    idx, {31'd0, ifRST}, {31'd0, v.eRst});
        chk("ifinstr",  idx, ifinstr, v.eInstr);
        chk("ifJAL",    idx, ifJALjump_addr, v.eJal);
        chk("fcount",   idx, fetch_count, v.eFc);
        chk("halted",   idx, {31'd0, halted}, {31'd0, v.eHalt});
    endtask

    initial begin
        // ihit load stall redir raddr | REN addr W RST instr jal fc halted
        addV(0, 32'h0, 0, 0, 32'h0,        1, 32'h0,   0, 0, 32'h0,   32'h4,   0, 0);
        // sequential fetch, imem[i]=i+1
        addV(1, 32'h1, 0, 0, 32'h0,        1, 32'h0,   1, 0, 32'h1,   32'h4,   0, 0);
        addV(1, 32'h2, 0, 0, 32'h0,        1, 32'h4,   1, 0, 32'h2,   32'h8,   1, 0);
        // stall at PC=8 for three cycles
        addV(1, 32'h3, 1, 0, 32'h0,        1, 32'h8,   0, 0, 32'h3,   32'hC,   2, 0);
        addV(1, 32'h63, 1, 0, 32'h0,       0, 32'h8,   0, 0, 32'h3,   32'hC,   2, 0);
        addV(0, 32'h0, 1, 0, 32'h0,        0, 32'h8,   0, 0, 32'h3,   32'hC,   2, 0);
        addV(0, 32'h0, 0, 0, 32'h0,        0, 32'h8,   1, 0, 32'h3,   32'hC,   2, 0);
        // fetch count 3, PC 12; park another word
        addV(1, 32'h5, 1, 0, 32'h0,        1, 32'hC,   0, 0, 32'h5,   32'h10,  3, 0);
        // redirect during HOLD to 0x103 -> 0x100
        addV(0, 32'h0, 1, 1, 32'h103,      0, 32'hC,   0, 1, 32'h5,   32'h10,  3, 0);
        addV(0, 32'h0, 0, 0, 32'h0,        1, 32'h100, 0, 0, 32'h0,   32'h104, 3, 0);
        // redirect with ihit: word dropped, count unchanged
        addV(1, 32'h7, 0, 1, 32'h200,      1, 32'h100, 0, 1, 32'h7,   32'h104, 3, 0);
        // HALT fetched directly
        addV(1, 32'hFFFF_FFFF, 0, 0, 32'h0, 1, 32'h200, 1, 0, 32'hFFFF_FFFF, 32'h204, 3, 0);
        addV(1, 32'h8, 0, 0, 32'h0,        0, 32'h204, 0, 0, 32'h8,   32'h208, 4, 1);
        addV(0, 32'h0, 0, 0, 32'h0,        0, 32'h204, 0, 0, 32'h0,   32'h208, 4, 1);
        // redirect out of HALTED to 0x40
        addV(0, 32'h0, 0, 1, 32'h40,       0, 32'h204, 0, 1, 32'h0,   32'h208, 4, 1);
        addV(0, 32'h0, 0, 0, 32'h0,        1, 32'h40,  0, 0, 32'h0,   32'h44,  4, 0);
        // HALT reached through HOLD
        addV(1, 32'hFFFF_FFFF, 1, 0, 32'h0, 1, 32'h40, 0, 0, 32'hFFFF_FFFF, 32'h44, 4, 0);
        addV(0, 32'h0, 0, 0, 32'h0,        0, 32'h40,  1, 0, 32'hFFFF_FFFF, 32'h44, 4, 0);
        // un-halt to 0xFFFFFFFF, masked to 0xFFFFFFFC
        addV(0, 32'h0, 0, 1, 32'hFFFF_FFFF, 0, 32'h44, 0, 1, 32'h0,   32'h48,  5, 1);
        // PC wrap, then four idle cycles
        addV(1, 32'h11, 0, 0, 32'h0,       1, 32'hFFFF_FFFC, 1, 0, 32'h11, 32'h0, 5, 0);
        for (int k = 0; k < 4; k++)
            addV(0, 32'h0, 0, 0, 32'h0,    1, 32'h0,   0, 0, 32'h0,   32'h4,   6, 0);
        // move to PC=4 and park a word for the reset test
        addV(1, 32'h21, 0, 0, 32'h0,       1, 32'h0,   1, 0, 32'h21,  32'h4,   6, 0);
        addV(1, 32'h22, 1, 0, 32'h0,       1, 32'h4,   0, 0, 32'h22,  32'h8,   7, 0);

        nRST = 1'b0;
        ihit = 1'b0;
        imemload = '0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_addr = '0;

        // reset state while nRST is held low
        @(negedge CLK);
        chk("rst_REN",  -1, {31'd0, imemREN}, 32'd1);
        chk("rst_addr", -1, imemaddr, 32'h0);
        chk("rst_W",    -1, {31'd0, ifW}, 32'd0);
        chk("rst_fc",   -1, fetch_count, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge CLK);
            #1;
            ihit          = vq[i].ihit;
            imemload      = vq[i].load;
            stall         = vq[i].stall;
            redirect      = vq[i].redir;
            redirect_addr = vq[i].raddr;
            @(negedge CLK);
            checkAll(i, vq[i]);
        end

        // DUT is now in HOLD at PC=4; assert reset between clock edges
        @(posedge CLK);
        #2;
        ihit     = 1'b0;
        stall    = 1'b1;
        imemload = 32'h33;
        chk("pre_REN", 100, {31'd0, imemREN}, 32'd0);
        chk("pre_ins", 100, ifinstr, 32'h22);
        nRST = 1'b0;
        #1;
        chk("ar_addr", 101, imemaddr, 32'h0);
        chk("ar_REN",  101, {31'd0, imemREN}, 32'd1);
        chk("ar_ins",  101, ifinstr, 32'h33);
        chk("ar_fc",   101, fetch_count, 32'h0);
        chk("ar_halt", 101, {31'd0, halted}, 32'd0);
        chk("ar_W",    101, {31'd0, ifW}, 32'd0);
        @(negedge CLK);
        nRST  = 1'b1;
        stall = 1'b0;
        ihit  = 1'b1;
        imemload = 32'h44;
        #1;
        chk("post_W",   102, {31'd0, ifW}, 32'd1);
        chk("post_ins", 102, ifinstr, 32'h44);
        @(posedge CLK);
        #1;
        ihit = 1'b0;
        chk("post_addr", 103, imemaddr, 32'h4);
        chk("post_fc",   103, fetch_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
